// File: rtl/cpu6_mtimer_pkg.sv
// Shared constants for the cpu6 machine timer: register offsets, control bit index and reset values.
package cpu6_mtimer_pkg;

    localparam int CPU6_XLEN = 32;

    // Byte offsets within the 32-byte timer window.
    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF        = 5'h10;
    localparam logic [4:0] PRESC_OFF       = 5'h14;
    localparam logic [4:0] RSVD6_OFF       = 5'h18;
    localparam logic [4:0] RSVD7_OFF       = 5'h1C;

    localparam int CTRL_EN = 0;

    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_PRESC       = 3'd5,
        REG_RSVD6       = 3'd6,
        REG_RSVD7       = 3'd7
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [4:0] offset);
        return reg_sel_e'(offset[4:2]);
    endfunction

endpackage

// File: rtl/cpu6_dfflr.sv
// Generic register with load enable and synchronous active-high reset to a parameterised value.
module cpu6_dfflr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu6_mtimer_presc.sv
// Prescaler for the machine timer: emits one tick every (divisor+1) enabled cycles.
module cpu6_mtimer_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PRESC_W-1:0] divisor,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] count;

    assign tick = en & (count == divisor);

    // A divisor write restarts the period so a shrinking divisor never strands the count above it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu6_mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled tick and registered interrupt to cpu6_core.
module cpu6_mtimer
    import cpu6_mtimer_pkg::*;
#(
    parameter int                 XLEN      = CPU6_XLEN,
    parameter int                 PRESC_W   = 8,
    parameter logic [PRESC_W-1:0] PRESC_RST = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sel,
    input  logic            memwrite,
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] writedata,
    output logic [XLEN-1:0] readdata,
    input  logic            csr_mtie_r,
    output logic            tmr_irq_r
);

    reg_sel_e               reg_sel;
    logic                   wr;
    logic                   wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_presc;
    logic                   tick;
    logic [XLEN-1:0]        mtime_lo, mtime_hi, cmp_lo, cmp_hi;
    logic [2*XLEN-1:0]      mtime, mtimecmp, mtime_inc;
    logic [XLEN-1:0]        mtime_lo_d, mtime_hi_d;
    logic                   ctrl_en;
    logic [PRESC_W-1:0]     presc;
    logic                   irq_d;
    logic                   unused_addr;

    assign unused_addr = ^addr[1:0];

    assign reg_sel     = decode_reg(addr);
    assign wr          = sel & memwrite;
    assign wr_mtime_lo = wr & (reg_sel == REG_MTIME_LO);
    assign wr_mtime_hi = wr & (reg_sel == REG_MTIME_HI);
    assign wr_cmp_lo   = wr & (reg_sel == REG_MTIMECMP_LO);
    assign wr_cmp_hi   = wr & (reg_sel == REG_MTIMECMP_HI);
    assign wr_ctrl     = wr & (reg_sel == REG_CTRL);
    assign wr_presc    = wr & (reg_sel == REG_PRESC);

    assign mtime     = {mtime_hi, mtime_lo};
    assign mtimecmp  = {cmp_hi, cmp_lo};
    assign mtime_inc = mtime + 1'b1;

    // A bus write owns its half; the other half still ticks but ignores any carry out of the written LO.
    assign mtime_lo_d = wr_mtime_lo ? writedata : mtime_inc[XLEN-1:0];
    assign mtime_hi_d = wr_mtime_hi ? writedata
                      : (wr_mtime_lo ? mtime_hi : mtime_inc[2*XLEN-1:XLEN]);

    cpu6_mtimer_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl_en),
        .divisor (presc),
        .clr     (wr_presc),
        .tick    (tick)
    );

    cpu6_dfflr #(.W(XLEN), .RST_VAL('0)) u_mtime_lo (
        .clk(clk), .reset(reset), .en(wr_mtime_lo | tick), .d(mtime_lo_d), .q(mtime_lo)
    );

    cpu6_dfflr #(.W(XLEN), .RST_VAL('0)) u_mtime_hi (
        .clk(clk), .reset(reset), .en(wr_mtime_hi | tick), .d(mtime_hi_d), .q(mtime_hi)
    );

    cpu6_dfflr #(.W(XLEN), .RST_VAL(CMP_RST[XLEN-1:0])) u_cmp_lo (
        .clk(clk), .reset(reset), .en(wr_cmp_lo), .d(writedata), .q(cmp_lo)
    );

    cpu6_dfflr #(.W(XLEN), .RST_VAL(CMP_RST[2*XLEN-1:XLEN])) u_cmp_hi (
        .clk(clk), .reset(reset), .en(wr_cmp_hi), .d(writedata), .q(cmp_hi)
    );

    cpu6_dfflr #(.W(1), .RST_VAL(1'b1)) u_ctrl_en (
        .clk(clk), .reset(reset), .en(wr_ctrl), .d(writedata[CTRL_EN]), .q(ctrl_en)
    );

    cpu6_dfflr #(.W(PRESC_W), .RST_VAL(PRESC_RST)) u_presc_reg (
        .clk(clk), .reset(reset), .en(wr_presc), .d(writedata[PRESC_W-1:0]), .q(presc)
    );

    // Level interrupt: held as long as the compare matches so the core keeps stalling until software acts.
    assign irq_d = csr_mtie_r & (mtime >= mtimecmp);

    cpu6_dfflr #(.W(1), .RST_VAL(1'b0)) u_irq (
        .clk(clk), .reset(reset), .en(1'b1), .d(irq_d), .q(tmr_irq_r)
    );

    always_comb begin
        readdata = '0;
        if (sel) begin
            case (reg_sel)
                REG_MTIME_LO:    readdata = mtime_lo;
                REG_MTIME_HI:    readdata = mtime_hi;
                REG_MTIMECMP_LO: readdata = cmp_lo;
                REG_MTIMECMP_HI: readdata = cmp_hi;
                REG_CTRL:        readdata = {{(XLEN-1){1'b0}}, ctrl_en};
                REG_PRESC:       readdata = XLEN'(presc);
                default:         readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_mtimer.sv
// Scoreboard bench for cpu6_mtimer: directed bus sequences push expectations, a negedge monitor checks them.
module tb_cpu6_mtimer;
    import cpu6_mtimer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        memwrite;
    logic [4:0]  addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        csr_mtie_r;
    logic        tmr_irq_r;

    int total = 0;
    int bad = 0;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    int          mon_kind;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    string       mon_name;

    cpu6_mtimer dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .memwrite   (memwrite),
        .addr       (addr),
        .writedata  (writedata),
        .readdata   (readdata),
        .csr_mtie_r (csr_mtie_r),
        .tmr_irq_r  (tmr_irq_r)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation pushed during a cycle is compared mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        while (kind_q.size() > 0) begin
            mon_kind = kind_q.pop_front();
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = (mon_kind == 0) ? readdata : {31'b0, tmr_irq_r};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("[TB] FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
        sel       = s;
        memwrite  = w;
        addr      = a;
        writedata = d;
    endtask

    // kind 0 checks readdata, kind 1 checks tmr_irq_r, both in the current cycle.
    task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'h0, 32'h0);
    endtask

    task automatic busRead(input logic [4:0] a, input logic [31:0] exp, input string name);
        applyStimulus(1'b1, 1'b0, a, 32'h0);
        checkOutput(0, exp, name);
        step(1);
        applyStimulus(1'b0, 1'b0, 5'h0, 32'h0);
    endtask

    task automatic irqCycle(input logic exp, input string name);
        checkOutput(1, {31'b0, exp}, name);
        step(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        reset      = 1'b1;
        csr_mtie_r = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'h0, 32'h0);
        step(3);
        reset = 1'b0;

        // Reset values; mtime ticks every cycle after the LO read.
        checkOutput(1, 32'h0, "rst_irq");
        busRead(MTIME_LO_OFF,    32'h0,         "rst_mtime_lo");
        busRead(MTIME_HI_OFF,    32'h0,         "rst_mtime_hi");
        busRead(MTIMECMP_LO_OFF, 32'hFFFF_FFFF, "rst_cmp_lo");
        busRead(MTIMECMP_HI_OFF, 32'hFFFF_FFFF, "rst_cmp_hi");
        busRead(CTRL_OFF,        32'h1,         "rst_ctrl");
        busRead(PRESC_OFF,       32'h0,         "rst_presc");
        busRead(RSVD6_OFF,       32'h0,         "rsvd6_zero");

        // Prescaler divisor 3: 40 enabled cycles give 10 ticks.
        busWrite(CTRL_OFF, 32'h0);
        busWrite(MTIME_LO_OFF, 32'h0);
        busWrite(MTIME_HI_OFF, 32'h0);
        busWrite(PRESC_OFF, 32'h3);
        busRead(PRESC_OFF, 32'h3, "presc_rb");
        busWrite(CTRL_OFF, 32'h1);
        step(40);
        busRead(MTIME_LO_OFF, 32'd10, "presc3_40cyc");
        busWrite(PRESC_OFF, 32'h0);
        busRead(MTIME_LO_OFF, 32'd10, "presc0_start");
        step(5);
        busRead(MTIME_LO_OFF, 32'd16, "presc0_rate");

        // LO carry into HI, then full 64-bit wrap.
        busWrite(CTRL_OFF, 32'h0);
        busWrite(MTIME_LO_OFF, 32'hFFFF_FFFE);
        busWrite(MTIME_HI_OFF, 32'h0);
        busWrite(CTRL_OFF, 32'h1);
        step(2);
        busRead(MTIME_LO_OFF, 32'h0, "carry_lo");
        busRead(MTIME_HI_OFF, 32'h1, "carry_hi");
        busWrite(CTRL_OFF, 32'h0);
        busWrite(MTIME_HI_OFF, 32'hFFFF_FFFF);
        busWrite(MTIME_LO_OFF, 32'hFFFF_FFFF);
        busWrite(CTRL_OFF, 32'h1);
        step(1);
        busRead(MTIME_LO_OFF, 32'h0, "wrap_lo");
        busRead(MTIME_HI_OFF, 32'h0, "wrap_hi");

        // Interrupt on mtime reaching mtimecmp=100, masking by MTIE, clearing by raising mtimecmp.
        busWrite(CTRL_OFF, 32'h0);
        busWrite(MTIME_LO_OFF, 32'd90);
        busWrite(MTIME_HI_OFF, 32'h0);
        busWrite(MTIMECMP_LO_OFF, 32'hFFFF_FFFF);
        busWrite(MTIMECMP_HI_OFF, 32'h0);
        busWrite(MTIMECMP_LO_OFF, 32'd100);
        busWrite(CTRL_OFF, 32'h1);
        step(10);
        irqCycle(1'b0, "irq_at_100_not_yet");
        irqCycle(1'b1, "irq_rise");
        csr_mtie_r = 1'b0;
        irqCycle(1'b1, "irq_mtie_clr_same");
        irqCycle(1'b0, "irq_mtie_clr_next");
        csr_mtie_r = 1'b1;
        irqCycle(1'b0, "irq_mtie_set_same");
        irqCycle(1'b1, "irq_mtie_set_next");
        checkOutput(1, 32'h1, "irq_cmp_hi_wr_same");
        busWrite(MTIMECMP_HI_OFF, 32'hFFFF_FFFF);
        irqCycle(1'b1, "irq_cmp_raised_same");
        irqCycle(1'b0, "irq_cmp_raised_next");
        busWrite(MTIMECMP_LO_OFF, 32'hFFFF_FFFF);
        checkOutput(1, 32'h0, "irq_cmp_max");
        busRead(MTIMECMP_LO_OFF, 32'hFFFF_FFFF, "cmp_lo_rb");
        busRead(MTIMECMP_HI_OFF, 32'hFFFF_FFFF, "cmp_hi_rb");

        // Write beats tick for LO without carry into HI; sel=0 ignores writes and reads zero.
        busWrite(CTRL_OFF, 32'h0);
        busWrite(MTIME_HI_OFF, 32'h7);
        busWrite(MTIME_LO_OFF, 32'hFFFF_FFFF);
        busWrite(CTRL_OFF, 32'h1);
        busWrite(MTIME_LO_OFF, 32'h5);
        busRead(MTIME_LO_OFF, 32'h5, "wr_tick_lo");
        busRead(MTIME_HI_OFF, 32'h7, "wr_tick_hi");
        applyStimulus(1'b0, 1'b1, CTRL_OFF, 32'h0);
        checkOutput(0, 32'h0, "nosel_read_zero");
        step(1);
        applyStimulus(1'b0, 1'b0, 5'h0, 32'h0);
        busRead(CTRL_OFF, 32'h1, "nosel_ctrl_kept");
        busRead(MTIME_LO_OFF, 32'h9, "nosel_mtime_runs");

        // Reset during a write with the interrupt asserted.
        busWrite(MTIMECMP_LO_OFF, 32'h0);
        busWrite(MTIMECMP_HI_OFF, 32'h0);
        step(1);
        checkOutput(1, 32'h1, "pre_reset_irq");
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, PRESC_OFF, 32'h5);
        step(1);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'h0, 32'h0);
        checkOutput(1, 32'h0, "post_reset_irq");
        busRead(MTIME_LO_OFF,    32'h0,         "post_reset_mtime_lo");
        busRead(MTIME_HI_OFF,    32'h0,         "post_reset_mtime_hi");
        busRead(MTIMECMP_LO_OFF, 32'hFFFF_FFFF, "post_reset_cmp_lo");
        busRead(MTIMECMP_HI_OFF, 32'hFFFF_FFFF, "post_reset_cmp_hi");
        busRead(CTRL_OFF,        32'h1,         "post_reset_ctrl");
        busRead(PRESC_OFF,       32'h0,         "post_reset_presc");

        step(2);
        if (kind_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
